xor_frame_accum: RTL and testbench

- Parametrised, clocked successor to the single-gate XOR primitive: a multi-channel XOR accumulator over framed input beats.
- Each of CH lanes of W bits is XOR-folded across a frame of up to FRAME_LEN beats.
- Per-lane result, per-lane parity bit, beat count and overlength flag are presented on a valid/ready output port.
- Sits between a streaming source and a checksum/consistency checker in the test datapath.

---
 rtl/xor_frame_pkg.sv | 23 ++
 rtl/xor_frame_accum_if.sv | 30 +++
 rtl/xor_frame_accum_lane.sv | 38 +++
 rtl/xor_frame_accum.sv | 140 ++++++++++++++
 tb/tb_xor_frame_accum.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/xor_frame_pkg.sv
// Shared types and helpers for the framed multi-lane XOR accumulator.
package xor_frame_pkg;

  // Frame controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Default lane width and the widest lane the masking helper supports.
  localparam int LANE_W = 8;
  localparam int MAX_W  = 64;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [MAX_W-1:0]  word_t;

  // A lane whose mask bit is clear contributes zero to the fold.
  function automatic word_t fold_masked(input word_t data, input logic mask);
    return mask ? data : '0;
  endfunction

endpackage

// File: rtl/xor_frame_accum_if.sv
// Beat input / result output bundle of the XOR frame accumulator.
// slave is the accumulator side, master is the source/consumer side.
interface xor_frame_accum_if #(
  parameter int CH = 4,
  parameter int W  = 8,
  parameter int CW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [CH*W-1:0]   in_data;
  logic [CH-1:0]     in_mask;
  logic              in_last;
  logic              odd_mode;
  logic              out_valid;
  logic              out_ready;
  logic [CH*W-1:0]   out_data;
  logic [CH-1:0]     out_parity;
  logic [CW-1:0]     out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_data, in_mask, in_last, odd_mode, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_mask, in_last, odd_mode, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_count, out_ovf
  );
endinterface

// File: rtl/xor_frame_accum_lane.sv
// Single-lane XOR accumulator. acc_d/parity_d expose the post-beat value so
// the parent can capture the closing result in the same edge.
module xor_lane_acc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic         xor_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc_d,
  output logic         parity_d
);

  logic [W-1:0] acc_q;

  // Next accumulator value: load starts a frame, xor folds a further beat.
  always_comb begin
    acc_d = acc_q;
    if (load_en) begin
      acc_d = din;
    end else if (xor_en) begin
      acc_d = acc_q ^ din;
    end
  end

  assign parity_d = ^acc_d;

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/xor_frame_accum.sv
// Multi-lane XOR accumulator over framed input beats.
//
//   state | meaning
//   IDLE  | no frame open, waiting for the first beat
//   ACCUM | frame open, folding further beats
//   HOLD  | result presented on out_*, waiting for out_ready
//
// In HOLD a beat may be accepted in the same cycle the result is consumed;
// it then opens the next frame exactly as from IDLE.
module xor_frame_accum
  import xor_frame_pkg::*;
#(
  parameter int CH        = 4,
  parameter int W         = 8,
  parameter int FRAME_LEN = 16
) (
  input logic              clk,
  input logic              rst,
  xor_frame_accum_if.slave bus
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            odd_q, odd_d;
  logic [CH*W-1:0] res_data_q, res_data_d;
  logic [CH-1:0]   res_par_q, res_par_d;
  logic [CW-1:0]   res_cnt_q, res_cnt_d;
  logic            res_ovf_q, res_ovf_d;

  logic            in_ready;
  logic            accept;
  logic            start_beat;
  logic            cont_beat;
  logic [CW-1:0]   beat_cnt;
  logic            at_limit;
  logic            close_frame;
  logic            odd_eff;
  logic [CH*W-1:0] acc_d_flat;
  logic [CH-1:0]   lane_par_d;

  // Beat qualification; in_ready depends on state and out_ready only.
  always_comb begin
    in_ready    = (state_q != HOLD) || bus.out_ready;
    accept      = bus.in_valid && in_ready;
    start_beat  = accept && (state_q != ACCUM);
    cont_beat   = accept && (state_q == ACCUM);
    beat_cnt    = start_beat ? CW'(1) : count_q + CW'(1);
    at_limit    = (beat_cnt == CW'(FRAME_LEN));
    close_frame = accept && (bus.in_last || at_limit);
    odd_eff     = start_beat ? bus.odd_mode : odd_q;
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic [W-1:0] din_c;

    assign din_c = W'(fold_masked(word_t'(bus.in_data[c*W +: W]), bus.in_mask[c]));

    xor_lane_acc #(.W(W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load_en  (start_beat),
      .xor_en   (cont_beat),
      .din      (din_c),
      .acc_d    (acc_d_flat[c*W +: W]),
      .parity_d (lane_par_d[c])
    );
  end

  // Next-state logic of the frame controller.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          state_d = close_frame ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (accept) begin
            state_d = close_frame ? HOLD : ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat counter, latched parity sense, and result capture at the closing beat.
  always_comb begin
    count_d    = accept ? beat_cnt : count_q;
    odd_d      = odd_eff;
    res_data_d = res_data_q;
    res_par_d  = res_par_q;
    res_cnt_d  = res_cnt_q;
    res_ovf_d  = res_ovf_q;
    if (close_frame) begin
      res_data_d = acc_d_flat;
      res_par_d  = lane_par_d ^ {CH{odd_eff}};
      res_cnt_d  = beat_cnt;
      res_ovf_d  = at_limit && !bus.in_last;
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      odd_q      <= 1'b0;
      res_data_q <= '0;
      res_par_q  <= '0;
      res_cnt_q  <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      odd_q      <= odd_d;
      res_data_q <= res_data_d;
      res_par_q  <= res_par_d;
      res_cnt_q  <= res_cnt_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.in_ready   = in_ready;
    bus.out_valid  = (state_q == HOLD);
    bus.out_data   = res_data_q;
    bus.out_parity = res_par_q;
    bus.out_count  = res_cnt_q;
    bus.out_ovf    = res_ovf_q;
  end

endmodule

// File: tb/tb_xor_frame_accum.sv
// Randomised and directed bench for xor_frame_accum against a frame-level model.
module tb_xor_frame_accum;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int FL = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  xor_frame_accum_if #(.CH(CH), .W(W), .CW(CW)) bus ();

  xor_frame_accum #(.CH(CH), .W(W), .FRAME_LEN(FL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: frame kept as a list of masked beats.
  logic [31:0] m_beats[$];
  logic        m_odd;
  logic        m_hold;
  logic [31:0] m_data;
  logic [3:0]  m_par;
  int          m_cnt;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] apply_mask(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r = '0;
    for (int c = 0; c < CH; c++) if (m[c]) r[c*W +: W] = d[c*W +: W];
    return r;
  endfunction

  task automatic model_clear();
    m_beats.delete();
    m_odd  = 1'b0;
    m_hold = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] d, input logic [3:0] m,
                            input logic l, input logic om, input logic ordy);
    logic acc;
    logic [31:0] x;
    acc = v && (!m_hold || ordy);
    if (m_hold && ordy) m_hold = 1'b0;
    if (acc) begin
      if (m_beats.size() == 0) m_odd = om;
      m_beats.push_back(apply_mask(d, m));
      if (l || m_beats.size() == FL) begin
        x = '0;
        foreach (m_beats[i]) x ^= m_beats[i];
        m_data = x;
        for (int c = 0; c < CH; c++) m_par[c] = (^x[c*W +: W]) ^ m_odd;
        m_cnt  = m_beats.size();
        m_ovf  = (m_beats.size() == FL) && !l;
        m_hold = 1'b1;
        m_beats.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
    if (m_hold) begin
      chk("out_data", 64'(bus.out_data), 64'(m_data));
      chk("out_parity", 64'(bus.out_parity), 64'(m_par));
      chk("out_count", 64'(bus.out_count), 64'(m_cnt));
      chk("out_ovf", 64'(bus.out_ovf), 64'(m_ovf));
    end
  endtask

  // One cycle: drive at negedge, check in_ready, update model at posedge, check outputs.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] m,
                      input logic l, input logic om, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_mask   = m;
    bus.in_last   = l;
    bus.odd_mode  = om;
    bus.out_ready = ordy;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(!m_hold || ordy));
    @(posedge clk);
    model_edge(v, d, m, l, om, ordy);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    model_clear();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_parity", 64'(bus.out_parity), 64'd0);
    chk("rst_count", 64'(bus.out_count), 64'd0);
    chk("rst_ovf", 64'(bus.out_ovf), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.in_mask = '0;
    bus.in_last = 0; bus.odd_mode = 0; bus.out_ready = 0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Abort a frame with reset after 3 beats, then a clean 2-beat frame.
    step(1, 32'hDEADBEEF, 4'hF, 0, 1, 0);
    step(1, 32'h12345678, 4'hF, 0, 1, 0);
    step(1, 32'hCAFEF00D, 4'hF, 0, 1, 0);
    do_reset();
    step(1, 32'h0F0F0F0F, 4'hF, 0, 0, 0);
    step(1, 32'hFF00FF00, 4'hF, 1, 0, 0);
    chk("t1_data", 64'(bus.out_data), 64'hF00FF00F);
    chk("t1_count", 64'(bus.out_count), 64'd2);

    // Three beats folding to zero, even parity sense.
    step(1, 32'h01020304, 4'hF, 0, 0, 1);
    step(1, 32'h10203040, 4'hF, 0, 0, 0);
    chk("t2_notyet", 64'(bus.out_valid), 64'd0);
    step(1, 32'h11223344, 4'hF, 1, 0, 0);
    chk("t2_data", 64'(bus.out_data), 64'h0);
    chk("t2_parity", 64'(bus.out_parity), 64'h0);
    chk("t2_count", 64'(bus.out_count), 64'd3);
    chk("t2_ovf", 64'(bus.out_ovf), 64'd0);

    // Same frame, lanes 0 and 2 only, odd parity sense (changed mid-frame: ignored).
    step(1, 32'h01020304, 4'b0101, 0, 1, 1);
    step(1, 32'h10203040, 4'b0101, 0, 0, 0);
    step(1, 32'h11223344, 4'b0101, 1, 0, 0);
    chk("t3_data", 64'(bus.out_data), 64'h0);
    chk("t3_parity", 64'(bus.out_parity), 64'hF);
    chk("t3_count", 64'(bus.out_count), 64'd3);
    step(0, 32'h0, 4'h0, 0, 0, 1);

    // 16 beats with in_last on the last one: full length, no overflow.
    for (int i = 0; i < FL; i++) step(1, 32'h00000100, 4'hF, i == FL - 1, 0, 0);
    chk("t4a_count", 64'(bus.out_count), 64'd16);
    chk("t4a_ovf", 64'(bus.out_ovf), 64'd0);
    step(0, 32'h0, 4'h0, 0, 0, 1);

    // 16 beats without in_last: closed by length, 17th beat stalls.
    for (int i = 0; i < FL; i++) step(1, 32'h00000001, 4'hF, 0, 0, 0);
    chk("t4_count", 64'(bus.out_count), 64'd16);
    chk("t4_ovf", 64'(bus.out_ovf), 64'd1);
    chk("t4_data", 64'(bus.out_data), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h00000001, 4'hF, 0, 0, 0);
      chk("t4_stall", 64'(bus.in_ready), 64'd0);
    end

    // Consume and accept a single-beat frame in the same cycle.
    step(1, 32'hA5A5A5A5, 4'hF, 1, 0, 1);
    chk("t5_valid", 64'(bus.out_valid), 64'd1);
    chk("t5_data", 64'(bus.out_data), 64'hA5A5A5A5);
    chk("t5_count", 64'(bus.out_count), 64'd1);

    // Long hold: outputs stay put, input stalled.
    for (int i = 0; i < 10; i++) begin
      step(1, $urandom, 4'hF, 0, 1, 0);
      chk("t6_data", 64'(bus.out_data), 64'hA5A5A5A5);
      chk("t6_ready", 64'(bus.in_ready), 64'd0);
    end
    step(0, 32'h0, 4'h0, 0, 0, 1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk);
        do_reset();
      end
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom), $urandom_range(0, 5) == 0,
           1'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
